// File: rtl/ray_column_sequencer.sv
// Column sequencer for the raycaster: snapshots the player pose per frame
// and streams one AXI-Stream beat per screen column under backpressure.
module ray_column_sequencer #(
    parameter int SCREEN_WIDTH = 320,
    parameter int HCOUNT_WIDTH = 9,
    parameter int POSE_WIDTH   = 16
) (
    input  logic                    pixel_clk_in,
    input  logic                    rst_in,
    input  logic                    frame_start_in,
    input  logic [1:0]              mode_in,
    input  logic [POSE_WIDTH-1:0]   posX_in,
    input  logic [POSE_WIDTH-1:0]   posY_in,
    input  logic [POSE_WIDTH-1:0]   dirX_in,
    input  logic [POSE_WIDTH-1:0]   dirY_in,
    input  logic [POSE_WIDTH-1:0]   planeX_in,
    input  logic [POSE_WIDTH-1:0]   planeY_in,
    input  logic                    column_tready_in,
    output logic                    column_tvalid_out,
    output logic [HCOUNT_WIDTH-1:0] column_hcount_out,
    output logic [POSE_WIDTH-1:0]   posX_out,
    output logic [POSE_WIDTH-1:0]   posY_out,
    output logic [POSE_WIDTH-1:0]   dirX_out,
    output logic [POSE_WIDTH-1:0]   dirY_out,
    output logic [POSE_WIDTH-1:0]   planeX_out,
    output logic [POSE_WIDTH-1:0]   planeY_out,
    output logic                    column_tlast_out,
    output logic                    busy_out,
    output logic                    frame_done_out,
    output logic                    field_out,
    output logic [7:0]              overrun_count_out
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int HW = HCOUNT_WIDTH;

    // Last column for each field parity in interlaced mode.
    localparam int LAST_F0 = (((SCREEN_WIDTH - 1) % 2) == 0) ?
                             SCREEN_WIDTH - 1 : SCREEN_WIDTH - 2;
    localparam int LAST_F1 = (((SCREEN_WIDTH - 1) % 2) == 1) ?
                             SCREEN_WIDTH - 1 : SCREEN_WIDTH - 2;

    localparam logic [HW-1:0] LAST_FULL = HW'(SCREEN_WIDTH - 1);
    localparam logic [HW-1:0] LAST_EVEN = HW'(LAST_F0);
    localparam logic [HW-1:0] LAST_ODD  = HW'(LAST_F1);

    state_t          state_q, state_d;
    logic [HW-1:0]   hcount_q, hcount_d;
    logic [HW-1:0]   last_q, last_d;
    logic            ilace_q, ilace_d;
    logic            tlast_q, tlast_d;
    logic            done_q, done_d;
    logic            field_q, field_d;
    logic [7:0]      ovr_q, ovr_d;

    logic [POSE_WIDTH-1:0] posx_q, posy_q;
    logic [POSE_WIDTH-1:0] dirx_q, diry_q;
    logic [POSE_WIDTH-1:0] plnx_q, plny_q;

    logic            start;
    logic            load;
    logic            hshake;
    logic            ilace_in;
    logic [HW-1:0]   step;
    logic [HW-1:0]   first_col;
    logic [HW-1:0]   last_col;
    logic [HW-1:0]   next_col;

    // Start qualification and column arithmetic for the next cycle.
    always_comb begin
        start     = (mode_in == 2'd0) || frame_start_in;
        load      = (state_q == IDLE) && start;
        hshake    = (state_q == EMIT) && column_tready_in;
        ilace_in  = (mode_in == 2'd2);
        step      = ilace_q ? HW'(2) : HW'(1);
        next_col  = hcount_q + step;
        first_col = LAST_FULL;
        last_col  = LAST_FULL;
        if (ilace_in) begin
            first_col = {{(HW-1){1'b0}}, field_q};
            last_col  = field_q ? LAST_ODD : LAST_EVEN;
        end else begin
            first_col = '0;
            last_col  = LAST_FULL;
        end
    end

    // Next-state logic for the frame FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        hcount_d = hcount_q;
        last_d   = last_q;
        ilace_d  = ilace_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        field_d  = field_q;
        ovr_d    = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = EMIT;
                    ilace_d  = ilace_in;
                    hcount_d = first_col;
                    last_d   = last_col;
                    tlast_d  = (first_col == last_col);
                end
            end
            EMIT: begin
                if (frame_start_in && (ovr_q != 8'hFF)) begin
                    ovr_d = ovr_q + 8'd1;
                end
                if (hshake) begin
                    if (tlast_q) begin
                        state_d = IDLE;
                        tlast_d = 1'b0;
                        done_d  = 1'b1;
                        if (ilace_q) begin
                            field_d = ~field_q;
                        end
                    end else begin
                        hcount_d = next_col;
                        tlast_d  = (next_col == last_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and column bookkeeping registers.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            hcount_q <= '0;
            last_q   <= '0;
            ilace_q  <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            field_q  <= 1'b0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            hcount_q <= hcount_d;
            last_q   <= last_d;
            ilace_q  <= ilace_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            field_q  <= field_d;
            ovr_q    <= ovr_d;
        end
    end

    // Pose snapshot, captured only on the frame start edge.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            posx_q <= '0;
            posy_q <= '0;
            dirx_q <= '0;
            diry_q <= '0;
            plnx_q <= '0;
            plny_q <= '0;
        end else if (load) begin
            posx_q <= posX_in;
            posy_q <= posY_in;
            dirx_q <= dirX_in;
            diry_q <= dirY_in;
            plnx_q <= planeX_in;
            plny_q <= planeY_in;
        end
    end

    // Outputs are direct register taps.
    always_comb begin
        column_tvalid_out = (state_q == EMIT);
        busy_out          = (state_q == EMIT);
        column_hcount_out = hcount_q;
        column_tlast_out  = tlast_q;
        frame_done_out    = done_q;
        field_out         = field_q;
        overrun_count_out = ovr_q;
        posX_out          = posx_q;
        posY_out          = posy_q;
        dirX_out          = dirx_q;
        dirY_out          = diry_q;
        planeX_out        = plnx_q;
        planeY_out        = plny_q;
    end

endmodule

// File: tb/tb_ray_column_sequencer.sv
// Scoreboard bench for ray_column_sequencer: three instances cover
// widths 320 (sync/backpressure/overrun), 7 (interlace) and 8 (free-run).
module tb_ray_column_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fs [3];
    logic [1:0]  mode [3];
    logic        rdy [3];
    logic [15:0] pxi, pyi, dxi, dyi, plxi, plyi;
    logic        tv [3];
    logic [8:0]  hc [3];
    logic [15:0] pxo [3], pyo [3], dxo [3], dyo [3], plxo [3], plyo [3];
    logic        tl [3], bz [3], fd [3], fld [3];
    logic [7:0]  ovr [3];

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        ray_column_sequencer #(
            .SCREEN_WIDTH((g == 0) ? 320 : ((g == 1) ? 7 : 8)),
            .HCOUNT_WIDTH(9),
            .POSE_WIDTH(16)
        ) u_dut (
            .pixel_clk_in(clk),
            .rst_in(rst),
            .frame_start_in(fs[g]),
            .mode_in(mode[g]),
            .posX_in(pxi),
            .posY_in(pyi),
            .dirX_in(dxi),
            .dirY_in(dyi),
            .planeX_in(plxi),
            .planeY_in(plyi),
            .column_tready_in(rdy[g]),
            .column_tvalid_out(tv[g]),
            .column_hcount_out(hc[g]),
            .posX_out(pxo[g]),
            .posY_out(pyo[g]),
            .dirX_out(dxo[g]),
            .dirY_out(dyo[g]),
            .planeX_out(plxo[g]),
            .planeY_out(plyo[g]),
            .column_tlast_out(tl[g]),
            .busy_out(bz[g]),
            .frame_done_out(fd[g]),
            .field_out(fld[g]),
            .overrun_count_out(ovr[g])
        );
    end

    typedef struct packed {
        logic [8:0]  h;
        logic        last;
        logic [15:0] px;
    } beat_t;

    beat_t q[$];
    beat_t e;
    int    errors = 0;
    int    checks = 0;
    int    sel    = 0;
    bit    mon_en = 1'b1;
    bit    pstall = 1'b0;
    logic [8:0]  phc;
    logic        ptl;
    logic [15:0] ppx;

    // Monitor: stall stability plus in-order scoreboard pop per handshake.
    always @(negedge clk) begin
        if (mon_en && pstall) begin
            checks++;
            if (tv[sel] !== 1'b1 || hc[sel] !== phc ||
                tl[sel] !== ptl || pxo[sel] !== ppx) begin
                errors++;
                $display("FAIL stall_hold: tv=%b hc=%0d tl=%b px=%h need hc=%0d tl=%b px=%h",
                         tv[sel], hc[sel], tl[sel], pxo[sel], phc, ptl, ppx);
            end
        end
        pstall <= mon_en && (tv[sel] === 1'b1) && !rdy[sel];
        phc    <= hc[sel];
        ptl    <= tl[sel];
        ppx    <= pxo[sel];
        if (mon_en && tv[sel] === 1'b1 && rdy[sel]) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got hc=%0d, none expected", hc[sel]);
            end else begin
                e = q.pop_front();
                if (hc[sel] !== e.h || tl[sel] !== e.last || pxo[sel] !== e.px) begin
                    errors++;
                    $display("FAIL beat: got hc=%0d tl=%b px=%h need hc=%0d tl=%b px=%h",
                             hc[sel], tl[sel], pxo[sel], e.h, e.last, e.px);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic push_frame(input int first, input int step, input int last);
        for (int c = first; c <= last; c += step) begin
            q.push_back('{h: 9'(c), last: (c == last), px: pxi});
        end
    endtask

    task automatic pulse(input int i);
        fs[i] = 1'b1;
        @(posedge clk);
        #1;
        fs[i] = 1'b0;
    endtask

    task automatic wait_drain(input int maxc, output int n);
        n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    function automatic logic all_zero(input int i);
        return !tv[i] && hc[i] == 0 && pxo[i] == 0 && pyo[i] == 0 &&
               dxo[i] == 0 && dyo[i] == 0 && plxo[i] == 0 && plyo[i] == 0 &&
               !tl[i] && !bz[i] && !fd[i] && !fld[i] && ovr[i] == 0;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (all_zero(i) !== 1'b1) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: tv=%b hc=%0d px=%h ovr=%0d need all 0",
                         i, tv[i], hc[i], pxo[i], ovr[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (tv[0] !== 1'b0 || bz[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: tv=%b bz=%b need 0 0", tv[0], bz[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sync_frame();
        int n;
        sel    = 0;
        rdy[0] = 1'b1;
        pxi    = 16'h1480;
        push_frame(0, 1, 319);
        pulse(0);
        wait_drain(400, n);
        checks++;
        if (q.size() != 0 || n != 320) begin
            errors++;
            $display("FAIL sync_len: cycles=%0d left=%0d need 320 0", n, q.size());
        end
        @(negedge clk);
        #1;
        checks++;
        if (fd[0] !== 1'b1 || tv[0] !== 1'b0 || bz[0] !== 1'b0) begin
            errors++;
            $display("FAIL sync_done: fd=%b tv=%b bz=%b need 1 0 0", fd[0], tv[0], bz[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fd[0] !== 1'b0 || tv[0] !== 1'b0) begin
            errors++;
            $display("FAIL sync_after: fd=%b tv=%b need 0 0", fd[0], tv[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int c;
        sel = 0;
        pxi = 16'h1480;
        push_frame(0, 1, 319);
        pulse(0);
        c = 0;
        while (q.size() != 0 && c < 3000) begin
            @(posedge clk);
            #1;
            rdy[0] = 1'($urandom_range(0, 1));
            if (c == 100) pxi = 16'h0480;
            c++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bp_timeout: left=%0d need 0", q.size());
        end
        @(negedge clk);
        #1;
        checks++;
        if (tv[0] !== 1'b0 || fd[0] !== 1'b1 || pxo[0] !== 16'h1480 || ovr[0] !== 8'd0) begin
            errors++;
            $display("FAIL bp_end: tv=%b fd=%b px=%h ovr=%0d need 0 1 1480 0",
                     tv[0], fd[0], pxo[0], ovr[0]);
        end
        @(posedge clk);
        #1;
        pxi    = 16'h1480;
        rdy[0] = 1'b1;
    endtask

    task automatic test_reset_midframe();
        int n;
        sel    = 0;
        rdy[0] = 1'b1;
        mon_en = 1'b0;
        pulse(0);
        repeat (100) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_zero(0) !== 1'b1) begin
            errors++;
            $display("FAIL midreset_zero: tv=%b hc=%0d px=%h bz=%b need all 0",
                     tv[0], hc[0], pxo[0], bz[0]);
        end
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (fd[0] !== 1'b0 || tv[0] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_nodone: fd=%b tv=%b need 0 0", fd[0], tv[0]);
            end
        end
        @(posedge clk);
        #1;
        q.delete();
        mon_en = 1'b1;
        push_frame(0, 1, 319);
        pulse(0);
        wait_drain(400, n);
        checks++;
        if (q.size() != 0 || n != 320) begin
            errors++;
            $display("FAIL midreset_restart: cycles=%0d left=%0d need 320 0", n, q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_interlace();
        int n;
        sel     = 1;
        mode[1] = 2'd2;
        rdy[1]  = 1'b1;
        checks++;
        if (fld[1] !== 1'b0) begin
            errors++;
            $display("FAIL il_field0: got %b need 0", fld[1]);
        end
        push_frame(0, 2, 6);
        pulse(1);
        wait_drain(20, n);
        checks++;
        if (q.size() != 0 || n != 4) begin
            errors++;
            $display("FAIL il_even_len: cycles=%0d left=%0d need 4 0", n, q.size());
        end
        @(negedge clk);
        #1;
        checks++;
        if (fld[1] !== 1'b1 || fd[1] !== 1'b1 || tv[1] !== 1'b0) begin
            errors++;
            $display("FAIL il_field1: fld=%b fd=%b tv=%b need 1 1 0", fld[1], fd[1], tv[1]);
        end
        @(posedge clk);
        #1;
        push_frame(1, 2, 5);
        pulse(1);
        wait_drain(20, n);
        checks++;
        if (q.size() != 0 || n != 3) begin
            errors++;
            $display("FAIL il_odd_len: cycles=%0d left=%0d need 3 0", n, q.size());
        end
        @(negedge clk);
        #1;
        checks++;
        if (fld[1] !== 1'b0 || fd[1] !== 1'b1) begin
            errors++;
            $display("FAIL il_field2: fld=%b fd=%b need 0 1", fld[1], fd[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_freerun();
        sel     = 2;
        rdy[2]  = 1'b1;
        push_frame(0, 1, 7);
        push_frame(0, 1, 7);
        mode[2] = 2'd0;
        @(posedge clk);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (tv[2] !== (i != 8) || fd[2] !== (i == 8)) begin
                errors++;
                $display("FAIL freerun_gap[%0d]: tv=%b fd=%b need %b %b",
                         i, tv[2], fd[2], (i != 8), (i == 8));
            end
        end
        mode[2] = 2'd1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (tv[2] !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL freerun_stop: tv=%b left=%0d need 0 0", tv[2], q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overrun();
        bit found;
        sel     = 0;
        mode[0] = 2'd1;
        rdy[0]  = 1'b0;
        q.delete();
        fs[0] = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (ovr[0] !== 8'd10) begin
            errors++;
            $display("FAIL ovr_count10: got %0d need 10", ovr[0]);
        end
        repeat (290) @(posedge clk);
        #1;
        fs[0] = 1'b0;
        checks++;
        if (ovr[0] !== 8'd255 || tv[0] !== 1'b1 || hc[0] !== 9'd0 || bz[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sat: ovr=%0d tv=%b hc=%0d bz=%b need 255 1 0 1",
                     ovr[0], tv[0], hc[0], bz[0]);
        end
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
        rdy[0] = 1'b1;
        push_frame(0, 1, 319);
        pulse(0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            #1;
            if (tv[0] === 1'b1 && hc[0] == 9'd319) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ovr_lastbeat: last column not seen, need hc=319");
        end
        fs[0] = 1'b1;
        @(posedge clk);
        #1;
        fs[0] = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ovr[0] !== 8'd1 || tv[0] !== 1'b0 || bz[0] !== 1'b0 || fd[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovr_lastedge: ovr=%0d tv=%b bz=%b fd=%b need 1 0 0 1",
                     ovr[0], tv[0], bz[0], fd[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (tv[0] !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL ovr_norestart: tv=%b left=%0d need 0 0", tv[0], q.size());
        end
    endtask

    initial begin
        rst  = 1'b1;
        pxi  = 16'h1111;
        pyi  = 16'h2222;
        dxi  = 16'h3333;
        dyi  = 16'h4444;
        plxi = 16'h5555;
        plyi = 16'h6666;
        for (int i = 0; i < 3; i++) begin
            fs[i]   = 1'b0;
            mode[i] = 2'd1;
            rdy[i]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_sync_frame();
        test_backpressure();
        test_reset_midframe();
        test_interlace();
        test_freerun();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ray_column_sequencer.md
# ray_column_sequencer

Parametrised column generator feeding the ray-calculation stage of the raycaster pipeline, replacing the bare hcount counter in the top level. Each frame it snapshots the player pose (pos/dir/plane), then emits one AXI-Stream beat per screen column (hcount plus the frozen pose) under ready/valid backpressure. It supports free-running, frame-synchronised and interlaced (even/odd column field) modes, and counts frame-start requests that arrive while a frame is still in flight.

## Interface
- SCREEN_WIDTH, 320: columns per frame, ≥2.
- HCOUNT_WIDTH, 9: column index width; must satisfy 2^HCOUNT_WIDTH ≥ SCREEN_WIDTH.
- POSE_WIDTH, 16: width of each pose word (signed 8.8 fixed point at default).
- pixel_clk_in, input, 1: the single clock for the block.
- rst_in, input, 1: asynchronous, active-high reset.
- frame_start_in, input, 1: single-cycle frame request, e.g. from the frame buffer's frame-done pulse.
- mode_in, input, 2: 0 = free-run, 1 = frame-synced, 2 = interlaced frame-synced, 3 = treated as 1.
- posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in, input, POSE_WIDTH each: live pose from the controller.
- column_tready_in, input, 1: downstream (DDA-in FIFO) ready.
- column_tvalid_out, output, 1: beat valid.
- column_hcount_out, output, HCOUNT_WIDTH: column index.
- posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out, output, POSE_WIDTH each: frame-frozen pose.
- column_tlast_out, output, 1: marks the last column beat of the frame.
- busy_out, output, 1: a frame is in progress.
- frame_done_out, output, 1: one-cycle pulse after the last beat is accepted.
- field_out, output, 1: field parity of the current or most recent interlaced frame.
- overrun_count_out, output, 8: count of ignored frame starts, saturating.

## Operation
- States: IDLE, EMIT.
- **IDLE**
  - column_tvalid_out = 0.
  - A start occurs when mode_in = 0, or when frame_start_in = 1 with mode_in ∈ {1, 2, 3}.
- **On a start edge**
  - Latch all six pose inputs into the *_out registers.
  - Latch the mode.
  - Step = 2 for interlaced, 1 otherwise.
  - First column = field for interlaced, 0 otherwise.
  - Go to EMIT.
- **Last column**
  - Step 1: SCREEN_WIDTH−1.
  - Interlaced: the largest column < SCREEN_WIDTH with parity equal to field.
  - column_tlast_out = 1 only while hcount equals the last column.
- **EMIT**
  - column_tvalid_out = 1.
  - On a handshake (valid & ready) at a non-last column: hcount += step.
  - On a handshake at the last column: go to IDLE, pulse frame_done_out next cycle; in interlaced mode, toggle field.
- AXI-S rule: while valid & !ready, hcount, pose and tlast hold stable.
- Pose changes on the *_in ports mid-frame have no effect until the next start.
- mode_in changes mid-frame have no effect until the next start.
- frame_start_in = 1 while in EMIT, including the edge of the last handshake:
  - the request is ignored;
  - overrun_count_out increments, saturating at 255.
- Free-run restarts from IDLE on the edge after the last handshake.
- busy_out = (state == EMIT).

## Timing
- Reset (async, immediate on rst_in rise) forces every output to 0: tvalid, hcount, all pose outs, tlast, busy, frame_done, field and overrun_count. The state goes to IDLE.
- Reset mid-frame abandons the frame. No frame_done pulse is produced and the field does not toggle.
- After rst_in falls, the first start can occur on the first rising edge.
- Start latency: with a start condition sampled at edge k, tvalid, hcount, pose and busy are valid after edge k.
- Throughput: with ready held high, one column per cycle.
- A step-1 frame takes SCREEN_WIDTH cycles. An interlaced frame takes ceil((SCREEN_WIDTH−field)/2) cycles.
- Free-run inserts exactly one idle cycle (tvalid = 0) between frames.
- For a last handshake at edge k:
  - frame_done_out is high for exactly the cycle after edge k;
  - busy_out is low after edge k;
  - field toggles at edge k.
- No combinational path from column_tready_in to any output. All outputs are registered.

## Test plan
- **Reset mid-frame:** mode 1, pulse frame_start_in, accept 100 beats, assert rst_in asynchronously between edges → all outputs 0 immediately, no frame_done pulse. Release reset, pulse start → hcount restarts at 0.
- **Frame-synced, constant ready:** mode 1, ready = 1, posX_in = 0x1480, single frame_start_in pulse → 320 consecutive beats with hcount 0..319, tlast only on 319, posX_out = 0x1480 throughout. frame_done pulses one cycle after beat 319, then tvalid stays 0.
- **Backpressure and pose freeze:** mode 1, ready toggled pseudo-randomly, posX_in changed to 0x0480 mid-frame → every hcount appears exactly once in order. Outputs stay stable while stalled. posX_out remains 0x1480.
- **Interlaced, SCREEN_WIDTH = 7:** mode 2, two starts → first frame emits 0, 2, 4, 6 with tlast on 6. Second frame emits 1, 3, 5 with tlast on 5. field_out reads 0, 1, 0 across the sequence.
- **Free-run:** mode 0, ready = 1, SCREEN_WIDTH = 8 → columns 0..7, one tvalid = 0 cycle, then 0..7 repeated. frame_done pulses coincide with the gap cycles.
- **Overrun saturation:** mode 1, ready = 0 after start, 300 frame_start_in pulses → overrun_count_out = 255, no restart occurs. A pulse on the same edge as the last handshake increments the count and does not start a frame.
